bit_unstuff: RTL and testbench
==============================

Name: bit_unstuff

Overview:
Receive-side counterpart of the transmit bit stuffer. Sits after the NRZI decoder and before the receive deserializer. Removes the 0 the transmitter inserts after every run of RUN_LEN consecutive 1s. Flags a bit-stuff error when a run exceeds RUN_LEN, and counts removed bits per packet.

Parameters:
RUN_LEN, 6, number of consecutive 1s after which the next bit is a stuffed bit.
CNT_W, 8, width of the per-packet removed-bit counter.

Ports:
Bit_Unstuff_Clk  input  1  single clock, all logic on rising edge
Bit_Unstuff_Rst  input  1  synchronous, active-high reset
Bit_Unstuff_Data_In  input  1  decoded serial bit
Bit_Unstuff_Data_In_Valid  input  1  qualifies Data_In; one bit per high cycle, gaps allowed
Bit_Unstuff_Pkt_Active  input  1  high from SOP to EOP; low = between packets
Bit_Unstuff_Data_Out  output  1  unstuffed bit
Bit_Unstuff_Data_Out_Valid  output  1  qualifies Data_Out, one-cycle strobe per forwarded bit
Bit_Unstuff_Flag  output  1  one-cycle pulse when a stuffed 0 is removed
Bit_Unstuff_Err  output  1  level; high while the packet is in error
Bit_Unstuff_Drop_Count  output  CNT_W  stuffed bits removed in current or last packet, saturating

Behaviour:
- Reset is synchronous and active-high: state IDLE, run counter 0, Data_Out 0, Data_Out_Valid 0, Flag 0, Err 0, Drop_Count 0.
- Clock: one clock, Bit_Unstuff_Clk; reset: Bit_Unstuff_Rst, synchronous, active-high.
- All outputs are registered. Latency is 1 cycle from an accepted input bit to Data_Out_Valid, Flag or Err.
- An input bit is accepted only in a cycle with Data_In_Valid=1 and Pkt_Active=1. Cycles without Data_In_Valid do not change the run counter.
- States: IDLE, COUNT, DROP, ERROR. The run counter is 3 bits wide, enough for RUN_LEN ≤ 7.
- IDLE: entered whenever Pkt_Active=0, from any state, on the next edge. Clears the run counter and Err.
  - Drop_Count is held in IDLE and cleared on the first cycle Pkt_Active=1.
  - An accepted bit in the first active cycle is processed exactly as in COUNT with counter 0.
- COUNT, accepted bit 0: forward it, counter ← 0.
- COUNT, accepted bit 1: forward it, counter ← counter+1. If the new counter equals RUN_LEN, go to DROP.
- DROP, accepted bit 0: not forwarded (Data_Out_Valid stays 0), Flag pulses 1 cycle, Drop_Count++ (saturating at all-ones), counter ← 0, go to COUNT.
- DROP, accepted bit 1: stuff error. Bit is not forwarded, Err ← 1, go to ERROR.
- ERROR: all bits discarded, no Data_Out_Valid, no Flag. Err stays high until Pkt_Active=0, then IDLE.
- Pkt_Active falling while in DROP: the pending stuffed bit is abandoned, no error raised, counter cleared.
- Pkt_Active=0 and Data_In_Valid=1 in the same cycle: the bit is ignored.
- Simultaneous reset and activity: reset wins.
- Reset mid-packet: next cycle is IDLE with all outputs at reset values. Bits are accepted again once Pkt_Active is sampled high.
- Data_Out holds its last value when Data_Out_Valid=0.

Decomposition:
- Shared USB package holds:
  - state encoding enum: IDLE=2'd0, COUNT=2'd1, DROP=2'd2, ERROR=2'd3;
  - the USB_STUFF_RUN_LEN=6 constant, which also feeds the transmit stuffer's threshold.
- No sub-module. The saturating counter stays inline.

Test Plan:
1. Pkt_Active=1, bits 0,1,1,1,1,1,1,0,1 → Data_Out stream 0,1,1,1,1,1,1,1. Flag pulses once, 1 cycle after the 8th input bit. Drop_Count=1, Err=0.
2. Bits 1×7 → first six forwarded, seventh not forwarded. Err=1 one cycle later. Following bits 0,1,0 produce no Data_Out_Valid. Err clears on the cycle after Pkt_Active=0.
3. Bits 1,1,1,1,1,0,1,1 (run of 5) → all 8 forwarded, Flag never pulses, Drop_Count=0.
4. Data_In_Valid gaps: 1,1,1 then 4 idle cycles then 1,1,1,0 → the 0 is dropped with a Flag pulse (gaps do not break the run). Total 6 bits forwarded.
5. Six 1s, then Pkt_Active=0 in DROP, then a new packet with bits 1,0 → both forwarded, no Flag, no Err, Drop_Count=0.
6. Three stuffing events in one packet, then Bit_Unstuff_Rst=1 for 1 cycle mid-packet → before reset Drop_Count=3. After reset all outputs are 0. A new packet counts from 0.

Source files
------------

// File: rtl/bit_unstuff_pkg.sv
// Shared USB bit-stuffing definitions.
// Used by both the transmit stuffer and the receive unstuffer.
package bit_unstuff_pkg;

  localparam int unsigned USB_STUFF_RUN_LEN = 6;

  localparam int unsigned USB_STUFF_CNT_W = 8;

  localparam int unsigned RUN_CNT_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DROP  = 2'd2,
    ERROR = 2'd3
  } unstuff_state_e;

endpackage

// File: rtl/bit_unstuff.sv
// Receive bit unstuffer: strips the 0 that follows a run of
// RUN_LEN ones, flags over-long runs, counts removed bits.
module bit_unstuff
  import bit_unstuff_pkg::*;
#(
  parameter int unsigned RUN_LEN = USB_STUFF_RUN_LEN,
  parameter int unsigned CNT_W   = USB_STUFF_CNT_W
) (
  input  logic             Bit_Unstuff_Clk,
  input  logic             Bit_Unstuff_Rst,
  input  logic             Bit_Unstuff_Data_In,
  input  logic             Bit_Unstuff_Data_In_Valid,
  input  logic             Bit_Unstuff_Pkt_Active,
  output logic             Bit_Unstuff_Data_Out,
  output logic             Bit_Unstuff_Data_Out_Valid,
  output logic             Bit_Unstuff_Flag,
  output logic             Bit_Unstuff_Err,
  output logic [CNT_W-1:0] Bit_Unstuff_Drop_Count
);

  localparam logic [RUN_CNT_W-1:0] RUN_MAX =
    RUN_CNT_W'(RUN_LEN);

  unstuff_state_e       state_q, state_d;
  logic [RUN_CNT_W-1:0] run_q, run_d;
  logic [RUN_CNT_W-1:0] run_cur;
  logic [RUN_CNT_W-1:0] run_inc;
  logic                 dout_q, dout_d;
  logic                 dval_q, dval_d;
  logic                 flag_q, flag_d;
  logic                 err_q, err_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [CNT_W-1:0]     cnt_sat;
  logic                 take;

  assign take = Bit_Unstuff_Data_In_Valid &
                Bit_Unstuff_Pkt_Active;

  assign cnt_sat = (cnt_q == '1) ? cnt_q
                 : cnt_q + CNT_W'(1);

  // Next state, run tracking and registered output values.
  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    dout_d  = dout_q;
    dval_d  = 1'b0;
    flag_d  = 1'b0;
    err_d   = err_q;
    cnt_d   = cnt_q;
    run_cur = (state_q == IDLE) ? '0 : run_q;
    run_inc = run_cur + RUN_CNT_W'(1);

    if (!Bit_Unstuff_Pkt_Active) begin
      state_d = IDLE;
      run_d   = '0;
      err_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE, COUNT: begin
          if (state_q == IDLE) begin
            cnt_d   = '0;
            err_d   = 1'b0;
            run_d   = '0;
            state_d = COUNT;
          end
          if (take) begin
            dval_d = 1'b1;
            dout_d = Bit_Unstuff_Data_In;
            if (Bit_Unstuff_Data_In) begin
              run_d = run_inc;
              if (run_inc == RUN_MAX) begin
                state_d = DROP;
              end
            end else begin
              run_d = '0;
            end
          end
        end
        DROP: begin
          if (take) begin
            if (!Bit_Unstuff_Data_In) begin
              flag_d  = 1'b1;
              cnt_d   = cnt_sat;
              run_d   = '0;
              state_d = COUNT;
            end else begin
              err_d   = 1'b1;
              state_d = ERROR;
            end
          end
        end
        ERROR: begin
          err_d = 1'b1;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State and output registers; reset takes priority.
  always_ff @(posedge Bit_Unstuff_Clk) begin
    if (Bit_Unstuff_Rst) begin
      state_q <= IDLE;
      run_q   <= '0;
      dout_q  <= 1'b0;
      dval_q  <= 1'b0;
      flag_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      dout_q  <= dout_d;
      dval_q  <= dval_d;
      flag_q  <= flag_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign Bit_Unstuff_Data_Out       = dout_q;
  assign Bit_Unstuff_Data_Out_Valid = dval_q;
  assign Bit_Unstuff_Flag           = flag_q;
  assign Bit_Unstuff_Err            = err_q;
  assign Bit_Unstuff_Drop_Count     = cnt_q;

endmodule

// File: tb/tb_bit_unstuff.sv
// Scoreboard bench for bit_unstuff.
// Directed vectors, hand-computed expected event stream.
module tb_bit_unstuff;

  logic       clk;
  logic       rst;
  logic       din;
  logic       dinv;
  logic       pkt;
  logic       dout;
  logic       dval;
  logic       flag;
  logic       err;
  logic [7:0] dcnt;

  int checks;
  int failures;

  typedef struct {
    logic f;
    logic d;
  } ev_t;

  ev_t q[$];

  bit_unstuff #(.RUN_LEN(6), .CNT_W(8)) dut (
    .Bit_Unstuff_Clk            (clk),
    .Bit_Unstuff_Rst            (rst),
    .Bit_Unstuff_Data_In        (din),
    .Bit_Unstuff_Data_In_Valid  (dinv),
    .Bit_Unstuff_Pkt_Active     (pkt),
    .Bit_Unstuff_Data_Out       (dout),
    .Bit_Unstuff_Data_Out_Valid (dval),
    .Bit_Unstuff_Flag           (flag),
    .Bit_Unstuff_Err            (err),
    .Bit_Unstuff_Drop_Count     (dcnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // One cycle of stimulus; returns at the negedge after the
  // sampling posedge, when outputs reflect this cycle's bit.
  task automatic cyc(input logic v, input logic b);
    din  = b;
    dinv = v;
    @(negedge clk);
    dinv = 1'b0;
  endtask

  // e: 0 no output, 1 forwarded, 2 removed with Flag.
  task automatic tx(input logic b, input int e);
    ev_t ev;
    if (e == 1) begin
      ev.f = 1'b0;
      ev.d = b;
      q.push_back(ev);
    end else if (e == 2) begin
      ev.f = 1'b1;
      ev.d = 1'b0;
      q.push_back(ev);
    end
    cyc(1'b1, b);
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while (q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk(nm, q.size(), 0);
    q.delete();
  endtask

  // Monitor: every output event must match the queue head.
  always @(negedge clk) begin
    if (dval || flag) begin
      if (dval && flag) begin
        checks++;
        failures++;
        $display("FAIL mon_both: dval=1 flag=1");
      end else if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL mon_extra: dval=%0b flag=%0b d=%0b",
                 dval, flag, dout);
      end else begin
        ev_t ev;
        ev = q.pop_front();
        chk("mon_kind", {31'd0, flag}, {31'd0, ev.f});
        if (!ev.f) chk("mon_data", {31'd0, dout}, {31'd0, ev.d});
      end
    end
  end

  initial begin
    checks   = 0;
    failures = 0;
    rst  = 1'b1;
    pkt  = 1'b0;
    din  = 1'b0;
    dinv = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_dout", {31'd0, dout}, 0);
    chk("rst_dval", {31'd0, dval}, 0);
    chk("rst_flag", {31'd0, flag}, 0);
    chk("rst_err", {31'd0, err}, 0);
    chk("rst_cnt", {24'd0, dcnt}, 0);
    rst = 1'b0;
    cyc(1'b0, 1'b0);

    // T1: single stuffed 0 removed
    pkt = 1'b1;
    tx(1'b0, 1);
    repeat (6) tx(1'b1, 1);
    tx(1'b0, 2);
    chk("t1_flag", {31'd0, flag}, 1);
    tx(1'b1, 1);
    chk("t1_flag_off", {31'd0, flag}, 0);
    chk("t1_cnt", {24'd0, dcnt}, 1);
    chk("t1_err", {31'd0, err}, 0);
    pkt = 1'b0;
    repeat (2) cyc(1'b0, 1'b0);
    chk("t1_cnt_hold", {24'd0, dcnt}, 1);
    drain("t1_drain");

    // T2: run of seven 1s -> stuff error
    pkt = 1'b1;
    repeat (6) tx(1'b1, 1);
    chk("t2_err_pre", {31'd0, err}, 0);
    tx(1'b1, 0);
    chk("t2_err", {31'd0, err}, 1);
    tx(1'b0, 0);
    tx(1'b1, 0);
    tx(1'b0, 0);
    chk("t2_err_hold", {31'd0, err}, 1);
    chk("t2_dout_hold", {31'd0, dout}, 1);
    chk("t2_cnt", {24'd0, dcnt}, 0);
    pkt = 1'b0;
    cyc(1'b0, 1'b0);
    chk("t2_err_clr", {31'd0, err}, 0);
    drain("t2_drain");

    // T3: run of five, nothing removed
    pkt = 1'b1;
    repeat (5) tx(1'b1, 1);
    tx(1'b0, 1);
    tx(1'b1, 1);
    tx(1'b1, 1);
    chk("t3_cnt", {24'd0, dcnt}, 0);
    chk("t3_err", {31'd0, err}, 0);
    pkt = 1'b0;
    cyc(1'b0, 1'b0);
    drain("t3_drain");

    // T4: valid gaps do not break the run
    pkt = 1'b1;
    repeat (3) tx(1'b1, 1);
    repeat (4) cyc(1'b0, 1'b0);
    repeat (3) tx(1'b1, 1);
    tx(1'b0, 2);
    chk("t4_cnt", {24'd0, dcnt}, 1);
    pkt = 1'b0;
    cyc(1'b0, 1'b0);
    drain("t4_drain");

    // T5: packet ends in DROP, inactive bit ignored
    pkt = 1'b1;
    repeat (6) tx(1'b1, 1);
    pkt = 1'b0;
    cyc(1'b1, 1'b0);
    pkt = 1'b1;
    tx(1'b1, 1);
    tx(1'b0, 1);
    chk("t5_err", {31'd0, err}, 0);
    chk("t5_cnt", {24'd0, dcnt}, 0);
    pkt = 1'b0;
    cyc(1'b0, 1'b0);
    drain("t5_drain");

    // T6: three removals, then reset mid-packet
    pkt = 1'b1;
    repeat (3) begin
      repeat (6) tx(1'b1, 1);
      tx(1'b0, 2);
    end
    chk("t6_cnt", {24'd0, dcnt}, 3);
    drain("t6_drain_a");
    rst = 1'b1;
    cyc(1'b1, 1'b1);
    rst = 1'b0;
    chk("t6_rst_dout", {31'd0, dout}, 0);
    chk("t6_rst_dval", {31'd0, dval}, 0);
    chk("t6_rst_flag", {31'd0, flag}, 0);
    chk("t6_rst_err", {31'd0, err}, 0);
    chk("t6_rst_cnt", {24'd0, dcnt}, 0);
    repeat (6) tx(1'b1, 1);
    tx(1'b0, 2);
    chk("t6_cnt_new", {24'd0, dcnt}, 1);
    pkt = 1'b0;
    cyc(1'b0, 1'b0);
    drain("t6_drain_b");

    // T7: removed-bit counter saturates
    pkt = 1'b1;
    repeat (260) begin
      repeat (6) tx(1'b1, 1);
      tx(1'b0, 2);
    end
    chk("t7_sat", {24'd0, dcnt}, 255);
    pkt = 1'b0;
    cyc(1'b0, 1'b0);
    drain("t7_drain");

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
